// File: rtl/sub12_serial_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and the default datapath width.
package sub12_serial_pkg;

  localparam int DEF_WIDTH = 12;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sub12_serial_if.sv
// Request/result bundle of sub12_serial. The master drives start/A/B, and the slave returns the result and flags.
// Handshake: start is only looked at while idle. busy is high for the whole serial run.
// done pulses for one cycle when out and the flags have just been loaded. They then hold until the next done.
interface sub12_serial_if #(
  parameter int WIDTH = sub12_serial_pkg::DEF_WIDTH
);
  import sub12_serial_pkg::*;

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             bout;
  logic             zero;
  logic             neg;
  logic             ovf;
  state_t           dbg_state;

  modport master (
    output start, A, B,
    input  busy, done, out, bout, zero, neg, ovf, dbg_state
  );

  modport slave (
    input  start, A, B,
    output busy, done, out, bout, zero, neg, ovf, dbg_state
  );

endinterface

// File: rtl/sub12_serial_full_subtractor.sv
// One-bit full subtractor cell. It computes a - b - bin and produces the difference bit and the borrow-out.
module full_subtractor (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);

  logic w_x;

  assign w_x    = i_a ^ i_b;
  assign o_d    = w_x ^ i_bin;
  assign o_bout = (~i_a & i_b) | (~w_x & i_bin);

endmodule

// File: rtl/sub12_serial.sv
// Bit-serial A - B, processed LSB first with one bit per clock. The result and flags are held in output
// registers that are separate from the working shift registers.
module sub12_serial
  import sub12_serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  sub12_serial_if.slave bus
);

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_res;
  logic [CNT_W-1:0] r_cnt;
  logic             r_bor;
  logic             r_sign_a;
  logic             r_sign_b;

  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_out;
  logic             r_bout;
  logic             r_zero;
  logic             r_neg;
  logic             r_ovf;

  logic             w_d;
  logic             w_bor_next;
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;

  full_subtractor u_fs (
    .i_a    (r_sa[0]),
    .i_b    (r_sb[0]),
    .i_bin  (r_bor),
    .o_d    (w_d),
    .o_bout (w_bor_next)
  );

  assign w_res_next = {w_d, r_res[WIDTH-1:1]};
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_sa     <= '0;
      r_sb     <= '0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_bor    <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_out    <= '0;
      r_bout   <= 1'b0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_sa     <= bus.A;
            r_sb     <= bus.B;
            r_sign_a <= bus.A[WIDTH-1];
            r_sign_b <= bus.B[WIDTH-1];
            r_bor    <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_res <= w_res_next;
          r_bor <= w_bor_next;
          r_cnt <= r_cnt + CNT_W'(1);
          // The last bit goes straight into the output registers instead of waiting a cycle in r_res.
          if (w_last) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_out   <= w_res_next;
            r_bout  <= w_bor_next;
            r_zero  <= (w_res_next == '0);
            r_neg   <= w_d;
            r_ovf   <= (r_sign_a != r_sign_b) && (w_d != r_sign_a);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.out       = r_out;
  assign bus.bout      = r_bout;
  assign bus.zero      = r_zero;
  assign bus.neg       = r_neg;
  assign bus.ovf       = r_ovf;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_sub12_serial.sv
// Self-checking bench for sub12_serial. It runs directed cases and then random operands.
// Results are compared against an integer-arithmetic model of A - B.
module tb_sub12_serial;
  import sub12_serial_pkg::*;

  localparam int W = 12;

  logic clock;
  logic reset_n;
  int   n_checks;
  int   n_errors;
  logic [W+3:0] exp_q[$];
  logic [W-1:0] prev_out;

  sub12_serial_if #(.WIDTH(W)) bus ();

  sub12_serial #(.WIDTH(W), .CNT_W(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: {ovf, neg, zero, bout, out}, computed from integer arithmetic.
  function automatic logic [W+3:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int ua, ub, sa, sb, sd, ud;
    logic [W-1:0] o;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
    sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
    sd = sa - sb;
    ud = (ua - ub) & ((1 << W) - 1);
    o  = W'(ud);
    return {(sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1), o[W-1], o == '0, ua < ub, o};
  endfunction

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    bus.A = a;
    bus.B = b;
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    bus.A = W'($urandom);
    bus.B = W'($urandom);
    exp_q.push_back(model(a, b));
    chk("busy_after_accept", 32'(bus.busy), 32'd1);
  endtask

  // Waits for done and checks the latency, the output hold and every result field.
  // When spur_at is nonzero, a start pulse is injected at that RUN cycle.
  task automatic wait_done(input int spur_at);
    int lat;
    logic [W+3:0] e;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock);
      #1;
      if (spur_at != 0 && i == spur_at) begin
        bus.A = W'(1);
        bus.B = W'(1);
        bus.start = 1'b1;
      end else if (spur_at != 0 && i == spur_at + 1) begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        lat = i;
        break;
      end
      chk("hold_out", 32'(bus.out), 32'(prev_out));
    end
    bus.start = 1'b0;
    chk("latency", 32'(lat), 32'(W));
    if (exp_q.size() == 0) begin
      chk("exp_q_nonempty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("out", 32'(bus.out), 32'(e[W-1:0]));
      chk("bout", 32'(bus.bout), 32'(e[W]));
      chk("zero", 32'(bus.zero), 32'(e[W+1]));
      chk("neg", 32'(bus.neg), 32'(e[W+2]));
      chk("ovf", 32'(bus.ovf), 32'(e[W+3]));
      chk("busy_at_done", 32'(bus.busy), 32'd0);
      prev_out = e[W-1:0];
    end
  endtask

  task automatic done_one_cycle();
    @(posedge clock);
    #1;
    chk("done_pulse_width", 32'(bus.done), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    prev_out = '0;
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_out", 32'(bus.out), 32'd0);
    chk("rst_flags", 32'({bus.bout, bus.zero, bus.neg, bus.ovf}), 32'd0);
    chk("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    @(negedge clock);
    reset_n = 1'b1;

    // Directed cases
    start_op(W'(100), W'(58));  wait_done(0); done_one_cycle();
    chk("basic_out", 32'(bus.out), 32'd42);
    start_op(W'(5), W'(7));     wait_done(0); done_one_cycle();
    chk("borrow_out", 32'(bus.out), 32'hFFE);
    start_op(W'('h800), W'(1)); wait_done(0); done_one_cycle();
    chk("ovf_flag", 32'(bus.ovf), 32'd1);
    start_op(W'('hABC), W'('hABC)); wait_done(0); done_one_cycle();
    chk("zero_flag", 32'(bus.zero), 32'd1);

    // A start while busy is ignored, and a start in the done cycle is accepted with no gap.
    start_op(W'(9), W'(4));
    wait_done(5);
    chk("ignore_out", 32'(bus.out), 32'd5);
    bus.A = W'(3);
    bus.B = W'(10);
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    exp_q.push_back(model(W'(3), W'(10)));
    chk("b2b_busy", 32'(bus.busy), 32'd1);
    chk("b2b_done_low", 32'(bus.done), 32'd0);
    wait_done(0);
    chk("b2b_out", 32'(bus.out), 32'hFF9);
    chk("b2b_bout", 32'(bus.bout), 32'd1);
    done_one_cycle();

    // A reset in the middle of a run aborts it.
    start_op(W'(20), W'(3));
    repeat (5) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_out", 32'(bus.out), 32'd0);
    void'(exp_q.pop_back());
    prev_out = '0;
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      chk("no_done_after_abort", 32'(bus.done), 32'd0);
    end
    start_op(W'(20), W'(3)); wait_done(0); done_one_cycle();
    chk("after_abort_out", 32'(bus.out), 32'd17);

    // Random operands with random idle gaps
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = (n % 8 == 0) ? ra : W'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clock);
      start_op(ra, rb);
      wait_done(0);
    end

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sub12_serial.md
Name: sub12_serial

Overview:
- Bit-serial, multi-cycle 12-bit subtractor: computes A - B one bit per clock, LSB first, with a start/busy/done handshake.
- Reverse-direction counterpart to the processor's ripple-carry adder path. Used where area matters more than latency, e.g. the branch-compare and address-decrement paths.
- Produces the difference, borrow-out, and zero/negative/signed-overflow flags.

Parameters:
- WIDTH, 12, operand/result width in bits; legal range 2..32.
- CNT_W, 4, width of the bit counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  single system clock; all state updates on its rising edge.
- reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  minuend; captured on the accepted start edge.
- B  input  WIDTH  subtrahend; captured on the accepted start edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result becomes valid.
- out  output  WIDTH  difference A - B mod 2^WIDTH.
- bout  output  1  final borrow; 1 iff A < B unsigned.
- zero  output  1  out == 0.
- neg  output  1  out[WIDTH-1].
- ovf  output  1  signed (two's-complement) overflow of A - B.

Behaviour:
- Reset (reset_n low at a clock edge):
  - state goes to IDLE;
  - busy, done, out, bout, zero, neg, ovf all go to 0;
  - internal shift registers, counter and borrow flop clear.
  - Reset wins over every other input in the same cycle.
  - Reset mid-RUN aborts the operation; no done pulse is produced.
- FSM states: IDLE, RUN.
- IDLE:
  - start=1 at an edge latches A into shift register sa and B into sb.
  - It also latches A[WIDTH-1] and B[WIDTH-1] into sign flops, clears the borrow flop and counter, and moves to RUN.
  - On that same edge busy goes to 1.
  - start=0 keeps the state in IDLE.
- RUN, on each edge:
  - d = sa[0] ^ sb[0] ^ bor
  - bor_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bor)
  - sa and sb shift right by one.
  - Result shift register shifts right with d entering at bit WIDTH-1.
  - Counter increments.
- Completion:
  - On the edge where the counter equals WIDTH-1, the last bit is processed and the state returns to IDLE.
  - On that edge: busy goes to 0, done goes to 1, and out/bout/zero/neg/ovf are loaded from the final values.
  - ovf = (signA != signB) & (final out MSB != signA).
- Latency: if start is accepted at edge k, done is high in the cycle after edge k+WIDTH (for WIDTH=12, 12 clocks after acceptance). done lasts exactly one cycle.
- Result hold: out and flags hold their values until the next completion or reset. They do not change during a subsequent RUN; internal working registers are separate from the outputs.
- start while busy: ignored. A and B are not resampled, and the in-flight operation is unaffected.
- Back-to-back: start high in the done cycle is accepted, since the state is IDLE. The new RUN begins with no idle gap; out holds the previous result until the new completion.
- A and B may change freely after the accepting edge.
- Width rules: all arithmetic is mod 2^WIDTH. bout is the unsigned borrow and is independent of ovf.

Decomposition:
- Shared package/header holds:
  - state encodings ST_IDLE=1'b0, ST_RUN=1'b1;
  - default WIDTH=12 constant, shared with the parallel adder users.
- One natural sub-module: full_subtractor (one-bit). Inputs a, b, bin; outputs d, bout. Instantiated once in the RUN datapath, mirroring the one-bit full_adder cell.

Test Plan:
- Basic: reset, then A=12'd100, B=12'd58, start pulse.
  - Required: done exactly 12 cycles after acceptance; out=12'd42, bout=0, zero=0, neg=0, ovf=0.
- Borrow: A=12'd5, B=12'd7.
  - Required: out=12'hFFE, bout=1, neg=1, ovf=0, zero=0.
- Signed overflow and zero:
  - A=12'h800, B=12'h001 -> out=12'h7FF, ovf=1, bout=0, neg=0.
  - Then A=B=12'hABC -> out=0, zero=1, bout=0.
- Busy/ignore and back-to-back:
  - Start 12'd9-12'd4.
  - Pulse start with A=12'd1, B=12'd1 at cycle 5 of RUN -> ignored; result out=5.
  - Assert start in the done cycle with A=12'd3, B=12'd10 -> accepted with no gap; out stays 5 until the next done, then 12'hFF9, bout=1.
- Reset mid-op: start 12'd20-12'd3, drive reset_n=0 at RUN cycle 6.
  - Required: at the next edge busy=0, done=0, out=0, and no done pulse follows.
  - Next operation 12'd20-12'd3 -> out=12'd17.
